// File: rtl/imem_loader_port.sv
// Instruction-memory responder: 256x16 store serving registered PC fetches,
// filled from address 0 by a byte-serial loader that stalls the core meanwhile.
module imem_loader_port #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               fetch_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               stall,
  input  logic               ld_start,
  input  logic [ADDR_W-1:0]  ld_len,
  input  logic [7:0]         ld_byte,
  input  logic               ld_byte_valid,
  output logic               ld_done
);
  typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, DONE} state_t;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0]  wr_ptr, len_latched;
  logic [7:0]         hi_byte;
  logic               wr_en, last_word, fetch_ok;

  assign last_word = (wr_ptr == len_latched);
  assign fetch_ok  = (state == IDLE) && fetch_req;
  assign stall     = (state != IDLE);
  assign ld_done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      IDLE:    if (ld_start) state_nxt = LOAD_HI;
      LOAD_HI: if (ld_byte_valid) state_nxt = LOAD_LO;
      LOAD_LO: if (ld_byte_valid) begin
        wr_en     = 1'b1;
        state_nxt = last_word ? DONE : LOAD_HI;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      wr_ptr      <= '0;
      len_latched <= '0;
      hi_byte     <= '0;
    end else begin
      instr_valid <= fetch_ok;
      if (fetch_ok) instr <= mem[pc_addr];
      if (state == IDLE && ld_start) begin
        len_latched <= ld_len;
        wr_ptr      <= '0;
      end
      if (state == LOAD_HI && ld_byte_valid) hi_byte <= ld_byte;
      // pointer parks on the last address so a 256-word load never wraps
      if (wr_en && !last_word) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // store is deliberately not reset so a loaded program survives rst
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= {hi_byte, ld_byte};
  end
endmodule

// File: tb/tb_imem_loader_port.sv
// Bench for imem_loader_port: vector table, directed load/reset sequences,
// and randomized loads/fetches against a word-level memory model.
module tb_imem_loader_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc_addr = '0;
  logic        fetch_req = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_len = '0;
  logic [7:0]  ld_byte = '0;
  logic        ld_byte_valid = 1'b0;
  logic        ld_done;

  imem_loader_port #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .fetch_req(fetch_req),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .ld_start(ld_start), .ld_len(ld_len), .ld_byte(ld_byte),
    .ld_byte_valid(ld_byte_valid), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_cycles = 0;
  int done_pulses = 0;
  logic [15:0] model_mem [256];
  logic [15:0] lw [256];
  logic [15:0] last_instr = '0;

  always @(negedge clk) begin
    if (stall === 1'b1) stall_cycles++;
    if (ld_done === 1'b1) done_pulses++;
  end

  typedef struct {
    logic        req;
    logic [7:0]  addr;
    logic        ev;
    logic [15:0] ei;
  } vec_t;
  vec_t vecs[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    ld_byte_valid = 1'b0;
    repeat (gaps) step();
    ld_byte = b;
    ld_byte_valid = 1'b1;
    step();
    ld_byte_valid = 1'b0;
  endtask

  // loads lw[0..len]; gap<0 means random gaps 0..2 before each byte
  task automatic load(input int len, input int gap, input string name);
    int s0, d0, tot, g;
    s0 = stall_cycles; d0 = done_pulses; tot = 0;
    ld_start = 1'b1; ld_len = 8'(len);
    step();
    ld_start = 1'b0;
    chk({name, "_stall_rise"}, {31'd0, stall}, 32'd1);
    for (int k = 0; k <= len; k++) begin
      for (int b = 0; b < 2; b++) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        tot += g;
        send_byte(b == 0 ? lw[k][15:8] : lw[k][7:0], g);
      end
      model_mem[k] = lw[k];
    end
    chk({name, "_done_pulse"}, {31'd0, ld_done}, 32'd1);
    step();
    chk({name, "_stall_fall"}, {31'd0, stall}, 32'd0);
    chk({name, "_stall_len"}, 32'(stall_cycles - s0), 32'(2 * (len + 1) + tot + 1));
    chk({name, "_done_cnt"}, 32'(done_pulses - d0), 32'd1);
  endtask

  task automatic fetch(input logic [7:0] a, input string name);
    fetch_req = 1'b1; pc_addr = a;
    step();
    fetch_req = 1'b0;
    chk({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({name, "_instr"}, {16'd0, instr}, {16'd0, model_mem[a]});
    last_instr = model_mem[a];
  endtask

  initial begin
    int d0;
    logic [7:0] a;
    // reset state
    step(); step();
    rst = 1'b0;
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, ld_done}, 32'd0);

    // 3-word load, then table of fetches / idle cycles
    lw[0] = 16'h1234; lw[1] = 16'h5678; lw[2] = 16'h9ABC;
    load(2, 0, "load3");
    vecs.push_back('{1'b1, 8'd0, 1'b1, 16'h1234});
    vecs.push_back('{1'b1, 8'd1, 1'b1, 16'h5678});
    vecs.push_back('{1'b1, 8'd2, 1'b1, 16'h9ABC});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 8'd7, 1'b0, 16'h9ABC});
    vecs.push_back('{1'b1, 8'd0, 1'b1, 16'h1234});
    vecs.push_back('{1'b0, 8'd2, 1'b0, 16'h1234});
    foreach (vecs[i]) begin
      fetch_req = vecs[i].req; pc_addr = vecs[i].addr;
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_instr", i), {16'd0, instr}, {16'd0, vecs[i].ei});
    end
    fetch_req = 1'b0;
    last_instr = 16'h1234;

    // full 256-word load, no wrap onto address 0
    for (int k = 0; k < 256; k++) lw[k] = {8'(k), ~8'(k)};
    load(255, 0, "full");
    fetch(8'd255, "full_255");
    chk("full_255_const", {16'd0, instr}, 32'hFF00);
    fetch(8'd0, "full_0");
    chk("full_0_const", {16'd0, instr}, 32'h00FF);

    // gapped load of the 3-word program
    lw[0] = 16'h1234; lw[1] = 16'h5678; lw[2] = 16'h9ABC;
    load(2, 3, "gap3");
    fetch(8'd0, "gap_0"); fetch(8'd1, "gap_1"); fetch(8'd2, "gap_2");
    chk("gap_2_const", {16'd0, instr}, 32'h9ABC);

    // reset after first word of a 4-word load
    d0 = done_pulses;
    ld_start = 1'b1; ld_len = 8'd3;
    step();
    ld_start = 1'b0;
    send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'hEF, 0);
    model_mem[0] = 16'hABCD;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_done", {31'd0, ld_done}, 32'd0);
    repeat (3) step();
    chk("midrst_nopulse", 32'(done_pulses - d0), 32'd0);
    fetch(8'd0, "midrst_f0");
    fetch(8'd1, "midrst_f1");
    lw[0] = 16'h4242;
    load(0, 0, "len0");
    fetch(8'd0, "len0_f0");
    fetch(8'd1, "len0_f1");

    // ld_start with fetch in IDLE; second ld_start/fetch in LOAD_HI ignored
    d0 = done_pulses;
    ld_start = 1'b1; ld_len = 8'd1; fetch_req = 1'b1; pc_addr = 8'd5;
    step();
    chk("both_valid", {31'd0, instr_valid}, 32'd1);
    chk("both_instr", {16'd0, instr}, {16'd0, model_mem[5]});
    chk("both_stall", {31'd0, stall}, 32'd1);
    last_instr = model_mem[5];
    ld_len = 8'd0; pc_addr = 8'd9;
    step();
    ld_start = 1'b0; fetch_req = 1'b0;
    chk("ign_valid", {31'd0, instr_valid}, 32'd0);
    chk("ign_instr", {16'd0, instr}, {16'd0, last_instr});
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    chk("ign_len_stall", {31'd0, stall}, 32'd1);
    chk("ign_len_done", {31'd0, ld_done}, 32'd0);
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    chk("ign_len_done2", {31'd0, ld_done}, 32'd1);
    step();
    chk("ign_cnt", 32'(done_pulses - d0), 32'd1);
    model_mem[0] = 16'h1122; model_mem[1] = 16'h3344;
    fetch(8'd0, "ign_f0"); fetch(8'd1, "ign_f1");

    // random loads and fetches against the model
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int len;
        len = int'($urandom_range(0, 15));
        for (int k = 0; k <= len; k++) lw[k] = 16'($urandom);
        load(len, -1, $sformatf("rload%0d", it));
      end else begin
        for (int j = 0; j < 6; j++) begin
          a = 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            fetch_req = 1'b0; pc_addr = a;
            step();
            chk($sformatf("ridle%0d_%0d_valid", it, j), {31'd0, instr_valid}, 32'd0);
            chk($sformatf("ridle%0d_%0d_instr", it, j), {16'd0, instr}, {16'd0, last_instr});
          end else begin
            fetch(a, $sformatf("rfetch%0d_%0d", it, j));
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader_port.md
# imem_loader_port

Instruction-memory responder for the 8-bit RISC core: the target end of the PC fetch path. It owns a 256 x 16 instruction store and answers fetch requests addressed by the PC register with a registered instruction word. A byte-serial program-load port fills the store from address 0. While loading, the block holds the core in stall.

## Interface
Parameters:
- ADDR_W, 8, fetch/store address width; depth = 2^ADDR_W
- INSTR_W, 16, instruction width; fixed at 2 load bytes per word

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- pc_addr  in  ADDR_W  fetch address, driven from the PC register output
- fetch_req  in  1  fetch strobe, sampled each clock
- instr  out  INSTR_W  fetched instruction word (registered)
- instr_valid  out  1  instr updated this cycle by a served fetch
- stall  out  1  high while a load is in progress; the core must freeze its PC
- ld_start  in  1  begin program load (accepted only in IDLE)
- ld_len  in  ADDR_W  words to load minus 1 (0 -> 1 word, 255 -> 256 words); sampled with ld_start
- ld_byte  in  8  load data byte; high byte of each word first
- ld_byte_valid  in  1  ld_byte valid this cycle
- ld_done  out  1  one-cycle pulse: last word written

## Operation
- FSM states: IDLE, LOAD_HI, LOAD_LO, DONE. Reset state is IDLE.
- IDLE:
  - fetch_req=1 -> instr <= mem[pc_addr] and instr_valid <= 1 on the next edge.
  - fetch_req=0 -> instr_valid <= 0; instr holds its last value.
  - ld_start=1 -> latch ld_len and clear wr_ptr to 0, then go to LOAD_HI.
  - If ld_start and fetch_req are both high in IDLE, the fetch is still served in that cycle.
- LOAD_HI: on ld_byte_valid, latch hi_byte and go to LOAD_LO. Otherwise wait; there is no timeout.
- LOAD_LO: on ld_byte_valid:
  - Write mem[wr_ptr] <= {hi_byte, ld_byte}.
  - If wr_ptr == len_latched, go to DONE.
  - Otherwise wr_ptr increments and the FSM returns to LOAD_HI.
- DONE: one cycle. ld_done=1 in this cycle, then return to IDLE.
- Fetch handling outside IDLE:
  - fetch_req is ignored in LOAD_HI, LOAD_LO and DONE.
  - instr_valid=0 in those states and instr holds its value.
- ld_start outside IDLE is ignored; it does not restart or extend the load.
- ld_byte_valid in IDLE or DONE is ignored.
- stall = (state != IDLE). It is decoded from the registered state, so it has no combinational path from inputs.
- Address arithmetic:
  - wr_ptr is ADDR_W bits.
  - With ld_len=255 the final write goes to address 255, and the FSM leaves via DONE with no wrap write to address 0.
  - Fetch accepts the full range 0..255.
- Memory is not cleared by rst; words already written survive reset. Unwritten locations are undefined.
- Reset mid-load: the FSM returns to IDLE, wr_ptr clears to 0, hi_byte is discarded, and no ld_done pulse is issued. The partial program remains in memory.

## Timing
- Reset values: instr=0, instr_valid=0, stall=0, ld_done=0, wr_ptr=0, state IDLE.
- Fetch latency is 1 clock: address and fetch_req at edge N produce instr/instr_valid after edge N+1. Back-to-back fetches give one word per clock.
- Load timing:
  - stall rises 1 clock after the edge that samples ld_start.
  - stall falls 1 clock after DONE, i.e. in the cycle after the ld_done pulse.
  - The minimum load of W words takes 2W+2 cycles from ld_start to stall low, with ld_byte_valid held high.
- Load-then-fetch: a word written in LOAD_LO is readable by any fetch in IDLE after DONE. There is no read-during-write case because fetches are blocked during load.

## Test plan
- Load 3 words (ld_len=2, bytes 12 34 56 78 9A BC), then fetch addr 0,1,2 back-to-back -> instr 0x1234, 0x5678, 0x9ABC on consecutive cycles. ld_done pulses once; stall is high for exactly 7 cycles.
- Full load (ld_len=255, word k = {k, ~k}), then fetch 255 and 0 -> 0xFF00 and 0x00FF. ld_done fires once, and address 0 is not overwritten at the end.
- Load with gaps (ld_byte_valid low for 3 cycles between bytes) -> same memory contents as the gap-free load; stall stays high throughout.
- Reset asserted after word 1 of a 4-word load -> stall=0 and ld_done=0 the next cycle, and no pulse follows. A fetch of addr 0 returns the written word. A new load with ld_len=0 then writes address 0.
- ld_start and fetch_req(addr 5) in the same IDLE cycle -> instr_valid=1 with mem[5] next cycle and stall rises the same cycle. A second ld_start and fetch_req during LOAD_HI are ignored: instr_valid=0 and the load length is unchanged.
- No fetch_req for 4 cycles after a fetch -> instr_valid=0 and instr holds the prior value.
